// File: rtl/proc_pkg.sv
// Shared processor constants and types used by the data memory,
// instruction memory and register file.
package proc_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DMEM_DEPTH = 64;

  typedef logic [31:0] word_t;

endpackage : proc_pkg

// File: rtl/data_memory.sv
// Word-organised data RAM for the MEM stage.
// - Reads are combinational.
// - Writes are synchronous.
// - Asynchronous reset reloads an image where word i holds i.
module data_memory
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int DEPTH  = proc_pkg::DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] addr_hi;
  logic              in_range;
  logic              wr_en_d;

  // The two low address bits select a byte inside the word, so they are dropped.
  // Any set bit above the word index means the access is out of range.
  // Out-of-range accesses never alias onto a stored word.
  always_comb begin
    word_idx = address[2+IDX_W-1:2];
    addr_hi  = address >> (IDX_W + 2);
    in_range = ~|addr_hi;
    wr_en_d  = write & in_range;
  end

  // Combinational read of the current array contents.
  // Out-of-range addresses read as zero.
  always_comb begin
    read_data = '0;
    if (in_range) begin
      read_data = mem_q[word_idx];
    end
  end

  // While reset is low, load the identity image and block writes.
  // Otherwise, perform an in-range store on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (wr_en_d) begin
      mem_q[word_idx] <= write_data;
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory.
// Expected read values are queued by the stimulus process.
// A separate monitor compares each expected value against read_data whenever a probe strobe fires.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  logic        probe;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  logic [31:0] exp_q  [$];
  string       name_q [$];

  data_memory #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on every probe, pop the oldest expectation and compare.
  initial begin
    forever begin
      @(posedge probe);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL probe_without_expectation: got read_data=0x%08h with no expected value queued", read_data);
      end else begin
        automatic logic [31:0] e  = exp_q.pop_front();
        automatic string       nm = name_q.pop_front();
        if (read_data === e) begin
          n_pass++;
          $display("check %-22s addr=%0d read_data=0x%08h ok", nm, address, read_data);
        end else begin
          n_fail++;
          $display("FAIL %s: addr=%0d read_data=0x%08h expected 0x%08h", nm, address, read_data, e);
        end
      end
    end
  end

  // Present an address and queue the expected combinational read.
  // This takes 3 ns, so a call that starts just after a clock edge finishes before the next edge.
  task automatic expect_rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    probe = 1'b1;
    #1;
    probe = 1'b0;
    #1;
  endtask

  // Perform a single-edge store driven from the falling edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    address    = addr;
    write_data = data;
    write      = 1'b1;
    @(negedge clk);
    write      = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_fail     = 0;
    probe      = 1'b0;
    rst_n      = 1'b0;
    write      = 1'b0;
    address    = '0;
    write_data = '0;

    // Reset image.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_rd("reset_img_12", 32'd12, 32'd3);
    expect_rd("reset_img_0", 32'd0, 32'd0);
    expect_rd("reset_img_252", 32'd252, 32'd63);
    expect_rd("reset_img_4", 32'd4, 32'd1);

    // Store/load, with neighbouring words left untouched.
    store(32'd20, 32'd0);
    #1;
    expect_rd("store_20", 32'd20, 32'd0);
    expect_rd("neighbour_16", 32'd16, 32'd4);
    expect_rd("neighbour_24", 32'd24, 32'd6);

    // Write-enable gating.
    @(negedge clk);
    address    = 32'd8;
    write_data = 32'hDEADBEEF;
    write      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    expect_rd("gated_8", 32'd8, 32'd2);
    store(32'd8, 32'hDEADBEEF);
    #1;
    expect_rd("enabled_8", 32'd8, 32'hDEADBEEF);

    // Misaligned addresses and range checks.
    expect_rd("misalign_23", 32'd23, 32'd0);
    expect_rd("misalign_10", 32'd10, 32'hDEADBEEF);
    expect_rd("oor_256", 32'd256, 32'd0);
    expect_rd("oor_high", 32'h8000_0000, 32'd0);
    store(32'd256, 32'h55);
    #1;
    expect_rd("no_wrap_0", 32'd0, 32'd0);
    expect_rd("oor_256_after", 32'd256, 32'd0);

    // Read-during-write on the same address.
    @(negedge clk);
    address    = 32'd4;
    write_data = 32'd7;
    write      = 1'b1;
    #1;
    expect_rd("rdw_before_4", 32'd4, 32'd1);
    @(posedge clk);
    #1;
    expect_rd("rdw_after_4", 32'd4, 32'd7);
    write = 1'b0;

    // Async reset between edges discards stored data immediately.
    store(32'd40, 32'hA5A5A5A5);
    #1;
    expect_rd("store_40", 32'd40, 32'hA5A5A5A5);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    expect_rd("async_rst_40", 32'd40, 32'd10);
    expect_rd("async_rst_4", 32'd4, 32'd1);

    // A write attempted while reset is held has no effect.
    write_data = 32'hFFFF_FFFF;
    address    = 32'd40;
    write      = 1'b1;
    @(posedge clk);
    #1;
    expect_rd("wr_in_reset_40", 32'd40, 32'd10);
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    #1;
    expect_rd("post_reset_40", 32'd40, 32'd10);
    expect_rd("post_reset_8", 32'd8, 32'd2);

    // After reset, stores land independently.
    store(32'd60, 32'h1234_5678);
    #1;
    expect_rd("indep_60", 32'd60, 32'h1234_5678);
    expect_rd("indep_56", 32'd56, 32'd14);
    expect_rd("indep_64", 32'd64, 32'd16);

    // Drain: every queued expectation must have been consumed.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_data_memory
